// File: rtl/debug_stepper.sv
// -----------------------------------------------------------------------------
// debug_stepper
//   Execution controller that gates the firmware under test through a
//   registered clock-enable. Supports free-run, halt, N-cycle single-step
//   and (optionally) a masked breakpoint on a 32-bit probe. Publishes a
//   32-bit status word for one lane of the debug capture wireout bus.
//
// Optional feature macro: DEBUG_STEPPER_BREAKPOINT_EN
//   defined   -> masked breakpoint compare is built and can halt the core
//   undefined -> bp_* ports are ignored, no halt with reason 3 is produced
//
// Ports:
//   clk          system clock (the debugged logic runs on it too)
//   reset        asynchronous, active-high reset
//   cmd_run      pulse: free-run
//   cmd_halt     pulse: stop
//   cmd_step     pulse: run step_count enabled cycles, then halt
//   cmd_clear    pulse: zero the enabled-cycle counter
//   step_count   cycles per step (0 is treated as 1), sampled with cmd_step
//   probe        observed value from the debugged logic
//   bp_value     breakpoint compare value
//   bp_mask      breakpoint bit mask, 1 = bit compared
//   bp_enable    breakpoint armed
//   core_ce      registered clock-enable to the debugged logic
//   halted       registered, high while HALTED
//   status_word  {state[1:0], halt_reason[1:0], zero-extended cycle_count}
// -----------------------------------------------------------------------------
module debug_stepper #(
  parameter int CNT_WIDTH  = 28,
  parameter int STEP_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_run,
  input  logic                  cmd_halt,
  input  logic                  cmd_step,
  input  logic                  cmd_clear,
  input  logic [STEP_WIDTH-1:0] step_count,
  input  logic [31:0]           probe,
  input  logic [31:0]           bp_value,
  input  logic [31:0]           bp_mask,
  input  logic                  bp_enable,
  output logic                  core_ce,
  output logic                  halted,
  output logic [31:0]           status_word
);

  typedef enum logic [1:0] {
    S_HALTED  = 2'd0,
    S_RUN     = 2'd1,
    S_STEP    = 2'd2,
    S_ILLEGAL = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    R_RESET     = 2'd0,
    R_HALT      = 2'd1,
    R_STEP_DONE = 2'd2,
    R_BREAK     = 2'd3
  } reason_t;

  state_t                state, next_state;
  reason_t               halt_reason, next_reason;
  logic [STEP_WIDTH-1:0] stepctr, next_stepctr;
  logic [STEP_WIDTH-1:0] step_load;
  logic [CNT_WIDTH-1:0]  cycle_count;
  logic [27:0]           cnt_ext;
  logic                  hit;

  // Breakpoint only counts on enabled cycles, so resuming on a probe that
  // still matches runs exactly one cycle before halting again.
`ifdef DEBUG_STEPPER_BREAKPOINT_EN
  assign hit = bp_enable & core_ce & (((probe ^ bp_value) & bp_mask) == 32'h0);
`else
  logic unused_bp;
  assign unused_bp = ^{probe, bp_value, bp_mask, bp_enable};
  assign hit       = 1'b0;
`endif

  // A zero step request still runs one cycle.
  assign step_load = (step_count == '0) ? STEP_WIDTH'(1) : step_count;

  // Priority inside each state: cmd_halt > breakpoint > step-done > cmd_step > cmd_run.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    next_state   = state;
    next_reason  = halt_reason;
    next_stepctr = stepctr;

    unique case (state)
      S_HALTED: begin
        if (cmd_halt) begin
          next_state = S_HALTED;          // no-op, reason held
        end else if (cmd_step) begin
          next_state   = S_STEP;
          next_stepctr = step_load;
        end else if (cmd_run) begin
          next_state = S_RUN;
        end
      end

      S_RUN: begin
        if (cmd_halt) begin
          next_state  = S_HALTED;
          next_reason = R_HALT;
        end else if (hit) begin
          next_state  = S_HALTED;
          next_reason = R_BREAK;
        end else if (cmd_step) begin
          next_state   = S_STEP;
          next_stepctr = step_load;
        end
      end

      S_STEP: begin
        // core_ce is always high in STEP, so the counter ticks every cycle.
        next_stepctr = stepctr - STEP_WIDTH'(1);
        if (cmd_halt) begin
          next_state  = S_HALTED;
          next_reason = R_HALT;
        end else if (hit) begin
          next_state  = S_HALTED;
          next_reason = R_BREAK;
        end else if (stepctr == STEP_WIDTH'(1)) begin
          next_state  = S_HALTED;
          next_reason = R_STEP_DONE;
        end else if (cmd_step) begin
          next_stepctr = step_load;
        end else if (cmd_run) begin
          next_state = S_RUN;
        end
      end

      default: begin
        next_state = S_HALTED;            // recover from the unused encoding
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_HALTED;
      halt_reason <= R_RESET;
      stepctr     <= '0;
      core_ce     <= 1'b0;
      halted      <= 1'b1;
    end else begin
      state       <= next_state;
      halt_reason <= next_reason;
      stepctr     <= next_stepctr;
      // Registered from next_state so both flags track state exactly.
      core_ce     <= (next_state == S_RUN) || (next_state == S_STEP);
      halted      <= (next_state == S_HALTED);
    end
  end

  // Clear wins over increment; the count survives halts and wraps freely.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_count <= '0;
    end else if (cmd_clear) begin
      cycle_count <= '0;
    end else if (core_ce) begin
      cycle_count <= cycle_count + CNT_WIDTH'(1);
    end
  end

  always_comb begin
    cnt_ext                 = '0;
    cnt_ext[CNT_WIDTH-1:0]  = cycle_count;
  end

  assign status_word = {state, halt_reason, cnt_ext};

endmodule

// File: tb/tb_debug_stepper.sv
// -----------------------------------------------------------------------------
// tb_debug_stepper
//   Directed self-checking bench for debug_stepper. A default-width instance
//   and a CNT_WIDTH=4 instance share all inputs; the narrow one is only
//   inspected for counter wrap. Inputs change 1 time unit after posedge and
//   outputs are sampled there too, well away from the active edge.
// -----------------------------------------------------------------------------
module tb_debug_stepper;

  logic        clk;
  logic        reset;
  logic        cmd_run, cmd_halt, cmd_step, cmd_clear;
  logic [15:0] step_count;
  logic [31:0] probe, bp_value, bp_mask;
  logic        bp_enable;

  logic        core_ce, halted;
  logic [31:0] status_word;
  logic        core_ce4, halted4;
  logic [31:0] status_word4;

  int total = 0;
  int bad   = 0;
  int exp_cnt;
  int exp_reason;

  debug_stepper dut (
    .clk(clk), .reset(reset),
    .cmd_run(cmd_run), .cmd_halt(cmd_halt), .cmd_step(cmd_step), .cmd_clear(cmd_clear),
    .step_count(step_count), .probe(probe), .bp_value(bp_value), .bp_mask(bp_mask),
    .bp_enable(bp_enable), .core_ce(core_ce), .halted(halted), .status_word(status_word)
  );

  debug_stepper #(.CNT_WIDTH(4)) dut4 (
    .clk(clk), .reset(reset),
    .cmd_run(cmd_run), .cmd_halt(cmd_halt), .cmd_step(cmd_step), .cmd_clear(cmd_clear),
    .step_count(step_count), .probe(probe), .bp_value(bp_value), .bp_mask(bp_mask),
    .bp_enable(bp_enable), .core_ce(core_ce4), .halted(halted4), .status_word(status_word4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mk(input int s, input int r, input int c);
    return {2'(s), 2'(r), 28'(c)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic r, input logic h, input logic s, input logic c);
    cmd_run = r; cmd_halt = h; cmd_step = s; cmd_clear = c;
    tick();
    cmd_run = 1'b0; cmd_halt = 1'b0; cmd_step = 1'b0; cmd_clear = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cmd_run = 0; cmd_halt = 0; cmd_step = 0; cmd_clear = 0;
    step_count = '0; probe = '0; bp_value = '0; bp_mask = '0; bp_enable = 1'b0;
    repeat (3) tick();
    total++;
    if (status_word !== 32'h0 || core_ce !== 1'b0 || halted !== 1'b1) begin
      bad++;
      $display("FAIL reset_held: ce=%b halted=%b status=%h, want ce=0 halted=1 status=0",
               core_ce, halted, status_word);
    end
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      total++;
      if (core_ce !== 1'b0 || halted !== 1'b1 || status_word !== 32'h0) begin
        bad++;
        $display("FAIL idle_after_reset[%0d]: ce=%b halted=%b status=%h, want 0/1/00000000",
                 i, core_ce, halted, status_word);
      end
    end
    exp_cnt = 0;
    exp_reason = 0;
  endtask

  task automatic test_step();
    int n;
    step_count = 16'd5;
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    n = 0;
    while (core_ce === 1'b1 && n < 100) begin
      n++;
      tick();
    end
    total++;
    if (n != 5) begin
      bad++;
      $display("FAIL step5_len: enabled=%0d want 5", n);
    end
    exp_cnt += 5; exp_reason = 2;
    total++;
    if (status_word !== mk(0, 2, exp_cnt) || halted !== 1'b1) begin
      bad++;
      $display("FAIL step5_status: status=%h halted=%b want %h halted=1",
               status_word, halted, mk(0, 2, exp_cnt));
    end

    // step_count of zero behaves as a single step
    step_count = 16'd0;
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    n = 0;
    while (core_ce === 1'b1 && n < 100) begin
      n++;
      tick();
    end
    total++;
    if (n != 1) begin
      bad++;
      $display("FAIL step0_len: enabled=%0d want 1", n);
    end
    exp_cnt += 1;
    total++;
    if (status_word !== mk(0, 2, exp_cnt)) begin
      bad++;
      $display("FAIL step0_status: status=%h want %h", status_word, mk(0, 2, exp_cnt));
    end
  endtask

  task automatic test_step_reload();
    int n;
    step_count = 16'd10;
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    n = 0;
    repeat (3) begin
      if (core_ce === 1'b1) n++;
      tick();
    end
    step_count = 16'd4;
    cmd_step = 1'b1;
    if (core_ce === 1'b1) n++;
    tick();
    cmd_step = 1'b0;
    while (core_ce === 1'b1 && n < 100) begin
      n++;
      tick();
    end
    total++;
    if (n != 8) begin
      bad++;
      $display("FAIL step_reload_len: enabled=%0d want 8", n);
    end
    exp_cnt += 8;
    total++;
    if (status_word !== mk(0, 2, exp_cnt)) begin
      bad++;
      $display("FAIL step_reload_status: status=%h want %h", status_word, mk(0, 2, exp_cnt));
    end
  endtask

  task automatic test_run_halt();
    int n;
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    n = 0;
    repeat (99) begin
      if (core_ce === 1'b1) n++;
      tick();
    end
    cmd_halt = 1'b1;
    if (core_ce === 1'b1) n++;
    tick();
    cmd_halt = 1'b0;
    total++;
    if (n != 100) begin
      bad++;
      $display("FAIL run_halt_len: enabled=%0d want 100", n);
    end
    exp_cnt += 100; exp_reason = 1;
    total++;
    if (status_word !== mk(0, 1, exp_cnt) || core_ce !== 1'b0 || halted !== 1'b1) begin
      bad++;
      $display("FAIL run_halt_status: status=%h ce=%b halted=%b want %h ce=0 halted=1",
               status_word, core_ce, halted, mk(0, 1, exp_cnt));
    end

    // halt outranks step in the same cycle
    step_count = 16'd3;
    pulse(1'b0, 1'b1, 1'b1, 1'b0);
    repeat (3) tick();
    total++;
    if (core_ce !== 1'b0 || halted !== 1'b1 || status_word !== mk(0, 1, exp_cnt)) begin
      bad++;
      $display("FAIL halt_step_same_cycle: ce=%b halted=%b status=%h want 0/1/%h",
               core_ce, halted, status_word, mk(0, 1, exp_cnt));
    end
  endtask

  task automatic test_breakpoint();
    int n;
    bp_mask = 32'h0000_FFFF;
    bp_value = 32'h0000_1234;
    bp_enable = 1'b1;
    probe = 32'h0;
`ifdef DEBUG_STEPPER_BREAKPOINT_EN
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    n = 0;
    // The debugged logic bumps probe on every enabled edge.
    while (core_ce === 1'b1 && n < 10000) begin
      n++;
      tick();
      probe = probe + 32'd1;
    end
    total++;
    if (n != 32'h1235) begin
      bad++;
      $display("FAIL bp_ramp_len: enabled=%0d want %0d", n, 32'h1235);
    end
    exp_cnt += 32'h1235; exp_reason = 3;
    total++;
    if (status_word !== mk(0, 3, exp_cnt)) begin
      bad++;
      $display("FAIL bp_ramp_status: status=%h want %h", status_word, mk(0, 3, exp_cnt));
    end

    // Probe held on a masked match: resume yields exactly one enabled cycle.
    probe = 32'hABCD_1234;
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    n = 0;
    while (core_ce === 1'b1 && n < 100) begin
      n++;
      tick();
    end
    total++;
    if (n != 1) begin
      bad++;
      $display("FAIL bp_resume_len: enabled=%0d want 1", n);
    end
    exp_cnt += 1;
    total++;
    if (status_word !== mk(0, 3, exp_cnt)) begin
      bad++;
      $display("FAIL bp_resume_status: status=%h want %h", status_word, mk(0, 3, exp_cnt));
    end
`else
    // Breakpoint compiled out: a matching probe must not stop the core.
    probe = 32'h0000_1234;
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (10) tick();
    total++;
    if (core_ce !== 1'b1) begin
      bad++;
      $display("FAIL bp_disabled_running: ce=%b want 1", core_ce);
    end
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    exp_cnt += 11; exp_reason = 1;
    total++;
    if (status_word !== mk(0, 1, exp_cnt)) begin
      bad++;
      $display("FAIL bp_disabled_status: status=%h want %h", status_word, mk(0, 1, exp_cnt));
    end
`endif
    bp_enable = 1'b0;
    probe = 32'h0;
  endtask

  task automatic test_wrap_clear();
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    exp_cnt = 0;
    total++;
    if (status_word !== mk(0, exp_reason, 0)) begin
      bad++;
      $display("FAIL clear_halted: status=%h want %h", status_word, mk(0, exp_reason, 0));
    end

    step_count = 16'd20;
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    repeat (25) tick();
    total++;
    if (status_word4 !== mk(0, 2, 4)) begin
      bad++;
      $display("FAIL wrap4_status: status=%h want %h", status_word4, mk(0, 2, 4));
    end
    total++;
    if (status_word !== mk(0, 2, 20)) begin
      bad++;
      $display("FAIL step20_status: status=%h want %h", status_word, mk(0, 2, 20));
    end

    // Clear during an enabled cycle wins over the increment.
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (3) tick();
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    total++;
    if (status_word !== mk(1, 2, 0)) begin
      bad++;
      $display("FAIL clear_running: status=%h want %h", status_word, mk(1, 2, 0));
    end
    tick();
    total++;
    if (status_word !== mk(1, 2, 1)) begin
      bad++;
      $display("FAIL count_after_clear: status=%h want %h", status_word, mk(1, 2, 1));
    end
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    exp_cnt = 2; exp_reason = 1;
    total++;
    if (status_word !== mk(0, 1, exp_cnt)) begin
      bad++;
      $display("FAIL halt_after_clear: status=%h want %h", status_word, mk(0, 1, exp_cnt));
    end
  endtask

  task automatic test_reset_mid_step();
    step_count = 16'd1000;
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    repeat (10) tick();
    total++;
    if (core_ce !== 1'b1) begin
      bad++;
      $display("FAIL mid_step_running: ce=%b want 1", core_ce);
    end
    reset = 1'b1;
    #1;
    total++;
    if (core_ce !== 1'b0 || halted !== 1'b1 || status_word !== 32'h0) begin
      bad++;
      $display("FAIL async_reset: ce=%b halted=%b status=%h want 0/1/00000000",
               core_ce, halted, status_word);
    end
    repeat (2) tick();
    reset = 1'b0;
    repeat (5) tick();
    total++;
    if (core_ce !== 1'b0 || halted !== 1'b1 || status_word !== 32'h0) begin
      bad++;
      $display("FAIL after_reset_release: ce=%b halted=%b status=%h want 0/1/00000000",
               core_ce, halted, status_word);
    end
  endtask

  initial begin
    test_reset();
    test_step();
    test_step_reload();
    test_run_halt();
    test_breakpoint();
    test_wrap_clear();
    test_reset_mid_step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
